// File: rtl/camera_csr.sv
// camera_csr: Avalon-MM control/status block for a frame-capture engine.
// Holds the run/continuous/abort controls, sticky done/overflow status,
// a frame counter and NUM_BUF frame-buffer base addresses. A three-state
// sequencer (IDLE/LAUNCH/WAIT) issues cap_start pulses and tracks cap_done.
//
// Ports:
//   avs_s1_clk, avs_s1_reset_n       clock, async active-low reset
//   avs_s1_address/read/write        Avalon-MM slave, fixed read latency 1
//   avs_s1_writedata/readdata        32-bit data, readdatavalid qualifies reads
//   cap_start, cap_base_addr         launch pulse and buffer base to capture engine
//   cap_done, cap_busy               end-of-frame pulse in, busy flag out
//   irq                              level interrupt (done & irq_en)
//
// Optional feature: define CAMERA_CSR_IRQ_EN to store CONTROL b2 and drive irq.
// Without it irq is tied low and CONTROL b2 reads 0.

module camera_csr #(
  parameter int unsigned NUM_BUF = 2,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned AW      = 32
) (
  input  logic              avs_s1_clk,
  input  logic              avs_s1_reset_n,
  input  logic [ADDR_W-1:0] avs_s1_address,
  input  logic              avs_s1_read,
  input  logic              avs_s1_write,
  input  logic [31:0]       avs_s1_writedata,
  output logic [31:0]       avs_s1_readdata,
  output logic              avs_s1_readdatavalid,
  output logic              cap_start,
  output logic [AW-1:0]     cap_base_addr,
  input  logic              cap_done,
  output logic              cap_busy,
  output logic              irq
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT} state_t;

  state_t        r_state;
  logic          r_run;
  logic          r_cont;
  logic          r_done;
  logic          r_ovf;
  logic [1:0]    r_buf_idx;
  logic [31:0]   r_frame_cnt;
  logic [AW-1:0] r_buf [NUM_BUF];

  logic          w_wr_ctrl;
  logic          w_wr_stat;
  logic          w_abort;
  logic          w_done_acc;
  logic          w_ovf_set;
  logic          w_irq_en;
  logic [AW-1:0] w_cur_base;
  logic [31:0]   w_rdata;
  logic [1:0]    w_idx_next;

  assign w_wr_ctrl  = avs_s1_write && (avs_s1_address == ADDR_W'(0));
  assign w_wr_stat  = avs_s1_write && (avs_s1_address == ADDR_W'(1));
  assign w_abort    = w_wr_ctrl && avs_s1_writedata[3];
  // Abort wins over a cap_done landing in the same cycle: the frame is dropped.
  assign w_done_acc = cap_done && (r_state == S_WAIT) && !w_abort;
  assign w_ovf_set  = cap_done && (r_state != S_WAIT);
  assign w_idx_next = (r_buf_idx == 2'(NUM_BUF - 1)) ? 2'd0 : r_buf_idx + 2'd1;

`ifdef CAMERA_CSR_IRQ_EN
  logic r_irq_en;
  logic r_irq;

  always_ff @(posedge avs_s1_clk or negedge avs_s1_reset_n) begin
    if (!avs_s1_reset_n) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr_ctrl) r_irq_en <= avs_s1_writedata[2];
      r_irq <= r_done && r_irq_en;
    end
  end

  assign w_irq_en = r_irq_en;
  assign irq      = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign irq      = 1'b0;
`endif

  always_comb begin
    w_cur_base = '0;
    for (int unsigned i = 0; i < NUM_BUF; i++) begin
      if (r_buf_idx == 2'(i)) w_cur_base = r_buf[i];
    end
  end

  always_comb begin
    w_rdata = '0;
    case (avs_s1_address)
      ADDR_W'(0): w_rdata = {29'd0, w_irq_en, r_cont, r_run};
      ADDR_W'(1): w_rdata = {26'd0, r_buf_idx, 1'b0, r_ovf, r_done, cap_busy};
      ADDR_W'(2): w_rdata = r_frame_cnt;
      default: begin
        for (int unsigned i = 0; i < NUM_BUF; i++) begin
          if (avs_s1_address == ADDR_W'(3 + i)) w_rdata = 32'(r_buf[i]);
        end
      end
    endcase
  end

  always_ff @(posedge avs_s1_clk or negedge avs_s1_reset_n) begin
    if (!avs_s1_reset_n) begin
      r_state              <= S_IDLE;
      r_run                <= 1'b0;
      r_cont               <= 1'b0;
      r_done               <= 1'b0;
      r_ovf                <= 1'b0;
      r_buf_idx            <= '0;
      r_frame_cnt          <= '0;
      cap_start            <= 1'b0;
      cap_busy             <= 1'b0;
      cap_base_addr        <= '0;
      avs_s1_readdata      <= '0;
      avs_s1_readdatavalid <= 1'b0;
      for (int unsigned i = 0; i < NUM_BUF; i++) r_buf[i] <= '0;
    end else begin
      // Read path samples pre-write register values.
      avs_s1_readdatavalid <= avs_s1_read;
      avs_s1_readdata      <= avs_s1_read ? w_rdata : '0;

      for (int unsigned i = 0; i < NUM_BUF; i++) begin
        if (avs_s1_write && (avs_s1_address == ADDR_W'(3 + i)))
          r_buf[i] <= AW'(avs_s1_writedata);
      end

      if (w_wr_ctrl) begin
        r_run  <= avs_s1_writedata[0] && !avs_s1_writedata[3];
        r_cont <= avs_s1_writedata[1];
      end else if (w_done_acc && !r_cont) begin
        r_run <= 1'b0;
      end

      // Set events take precedence over a same-cycle W1C.
      r_done <= w_done_acc || (r_done && !(w_wr_stat && avs_s1_writedata[1]));
      r_ovf  <= w_ovf_set  || (r_ovf  && !(w_wr_stat && avs_s1_writedata[2]));

      if (w_done_acc) begin
        r_frame_cnt <= r_frame_cnt + 32'd1;
        r_buf_idx   <= w_idx_next;
      end

      if (w_abort) begin
        r_state   <= S_IDLE;
        cap_start <= 1'b0;
        cap_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: if (r_run) begin
            r_state       <= S_LAUNCH;
            cap_start     <= 1'b1;
            cap_busy      <= 1'b1;
            cap_base_addr <= w_cur_base;
          end
          S_LAUNCH: begin
            r_state   <= S_WAIT;
            cap_start <= 1'b0;
          end
          S_WAIT: if (cap_done) begin
            r_state  <= S_IDLE;
            cap_busy <= 1'b0;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_camera_csr.sv
module tb_camera_csr;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  addr = '0;
  logic        rd = 1'b0;
  logic        wr = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rdv;
  logic        cap_start;
  logic [31:0] cap_base_addr;
  logic        cap_done = 1'b0;
  logic        cap_busy;
  logic        irq;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  camera_csr #(.NUM_BUF(2), .ADDR_W(3), .AW(32)) dut (
    .avs_s1_clk          (clk),
    .avs_s1_reset_n      (rst_n),
    .avs_s1_address      (addr),
    .avs_s1_read         (rd),
    .avs_s1_write        (wr),
    .avs_s1_writedata    (wdata),
    .avs_s1_readdata     (rdata),
    .avs_s1_readdatavalid(rdv),
    .cap_start           (cap_start),
    .cap_base_addr       (cap_base_addr),
    .cap_done            (cap_done),
    .cap_busy            (cap_busy),
    .irq                 (irq)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] exp_rdata;
    logic        exp_start;
    logic        exp_busy;
    logic [31:0] exp_base;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(logic r, logic w, logic [2:0] a, logic [31:0] d, logic dn,
                              logic [31:0] er, logic es, logic eb, logic [31:0] ebase);
    vec_t v;
    v.rd = r; v.wr = w; v.addr = a; v.wdata = d; v.done = dn;
    v.exp_rdata = er; v.exp_start = es; v.exp_busy = eb; v.exp_base = ebase;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic do_read(input string name, input logic [2:0] a, input logic [31:0] exp);
    @(negedge clk);
    rd = 1'b1; addr = a;
    @(negedge clk);
    rd = 1'b0;
    check(name, {rdv, rdata}, {1'b1, exp});
  endtask

  task automatic pulse_done();
    @(negedge clk);
    cap_done = 1'b1;
    @(negedge clk);
    cap_done = 1'b0;
  endtask

  task automatic wait_start(input string name, output int cyc);
    cyc = 0;
    while (!cap_start && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!cap_start) check(name, 128'd0, 128'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  logic [31:0] exp_seq[3];
  int          cyc;
  int          seen;

  initial begin
    // cycle-accurate vectors: inputs held for one edge, outputs checked at next negedge
    vecs[0]  = mk(1, 0, 1, 0,       0, 32'h0,    0, 0, 32'h0);
    vecs[1]  = mk(0, 1, 3, 32'h1000,0, 32'h0,    0, 0, 32'h0);
    vecs[2]  = mk(0, 1, 4, 32'h2000,0, 32'h0,    0, 0, 32'h0);
    vecs[3]  = mk(1, 0, 3, 0,       0, 32'h1000, 0, 0, 32'h0);
    vecs[4]  = mk(1, 0, 4, 0,       0, 32'h2000, 0, 0, 32'h0);
    vecs[5]  = mk(1, 0, 7, 0,       0, 32'h0,    0, 0, 32'h0);
    vecs[6]  = mk(0, 1, 0, 32'h1,   0, 32'h0,    0, 0, 32'h0);
    vecs[7]  = mk(0, 0, 0, 0,       0, 32'h0,    1, 1, 32'h1000);
    vecs[8]  = mk(0, 0, 0, 0,       0, 32'h0,    0, 1, 32'h1000);
    vecs[9]  = mk(1, 0, 1, 0,       0, 32'h1,    0, 1, 32'h1000);
    vecs[10] = mk(0, 0, 0, 0,       1, 32'h0,    0, 0, 32'h1000);
    vecs[11] = mk(1, 0, 1, 0,       0, 32'h12,   0, 0, 32'h1000);
    vecs[12] = mk(1, 0, 2, 0,       0, 32'h1,    0, 0, 32'h1000);
    vecs[13] = mk(1, 0, 0, 0,       0, 32'h0,    0, 0, 32'h1000);
    vecs[14] = mk(0, 1, 1, 32'h2,   0, 32'h0,    0, 0, 32'h1000);
    vecs[15] = mk(1, 0, 1, 0,       0, 32'h10,   0, 0, 32'h1000);
    vecs[16] = mk(0, 0, 0, 0,       1, 32'h0,    0, 0, 32'h1000);
    vecs[17] = mk(1, 0, 1, 0,       0, 32'h14,   0, 0, 32'h1000);
    vecs[18] = mk(0, 1, 1, 32'h4,   0, 32'h0,    0, 0, 32'h1000);
    vecs[19] = mk(1, 0, 1, 0,       0, 32'h10,   0, 0, 32'h1000);
    vecs[20] = mk(1, 1, 3, 32'h3000,0, 32'h1000, 0, 0, 32'h1000);
    vecs[21] = mk(1, 0, 3, 0,       0, 32'h3000, 0, 0, 32'h1000);
    vecs[22] = mk(0, 1, 2, 32'hFFFF,0, 32'h0,    0, 0, 32'h1000);
    vecs[23] = mk(1, 0, 2, 0,       0, 32'h1,    0, 0, 32'h1000);
    vecs[24] = mk(0, 1, 1, 32'h4,   1, 32'h0,    0, 0, 32'h1000);
    vecs[25] = mk(1, 0, 1, 0,       0, 32'h14,   0, 0, 32'h1000);

    // reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs", {rdv, rdata, cap_start, cap_busy, irq, cap_base_addr},
          {1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0});
    rst_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      rd = vecs[i].rd; wr = vecs[i].wr; addr = vecs[i].addr;
      wdata = vecs[i].wdata; cap_done = vecs[i].done;
      @(negedge clk);
      rd = 1'b0; wr = 1'b0; cap_done = 1'b0;
      check($sformatf("vec%0d", i),
            {rdv, (vecs[i].rd ? rdata : 32'h0), cap_start, cap_busy, cap_base_addr},
            {vecs[i].rd, vecs[i].exp_rdata, vecs[i].exp_start, vecs[i].exp_busy, vecs[i].exp_base});
    end

    // continuous mode: buffer rotation, start-to-start gap, then abort racing cap_done
    do_reset();
    do_write(3, 32'h1000);
    do_write(4, 32'h2000);
    do_write(0, 32'h3);
    exp_seq[0] = 32'h1000; exp_seq[1] = 32'h2000; exp_seq[2] = 32'h1000;
    for (int f = 0; f < 3; f++) begin
      wait_start($sformatf("cont_start%0d_timeout", f), cyc);
      if (f > 0) check($sformatf("cont_gap%0d", f), 128'(cyc), 128'd1);
      check($sformatf("cont_base%0d", f), 128'(cap_base_addr), 128'(exp_seq[f]));
      repeat (10) @(negedge clk);
      pulse_done();
    end
    wait_start("cont_start3_timeout", cyc);
    check("cont_base3", 128'(cap_base_addr), 128'h2000);
    @(negedge clk);
    wr = 1'b1; addr = 3'd0; wdata = 32'h8; cap_done = 1'b1;
    @(negedge clk);
    wr = 1'b0; cap_done = 1'b0;
    check("abort_busy_start", {cap_busy, cap_start}, 2'b00);
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (cap_start || cap_busy) seen++;
    end
    check("abort_stays_idle", 128'(seen), 128'd0);
    do_read("abort_frame_count", 2, 32'd3);
    do_read("abort_status", 1, 32'h12);
    do_read("abort_control", 0, 32'h0);

    // reset while a frame is in flight
    do_write(0, 32'h1);
    wait_start("midrst_start_timeout", cyc);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {cap_start, cap_busy, cap_base_addr}, {1'b0, 1'b0, 32'h0});
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (cap_start || cap_busy) seen++;
    end
    check("midrst_no_relaunch", 128'(seen), 128'd0);
    do_read("midrst_status", 1, 32'h0);
    do_read("midrst_buf0", 3, 32'h0);

    // interrupt path
    do_write(3, 32'h1000);
    do_write(0, 32'h5);
    wait_start("irq_start_timeout", cyc);
    @(negedge clk);
    @(negedge clk);
    pulse_done();
    @(negedge clk);
`ifdef CAMERA_CSR_IRQ_EN
    check("irq_assert", 128'(irq), 128'd1);
`else
    check("irq_tied_low", 128'(irq), 128'd0);
`endif
    do_write(1, 32'h2);
    @(negedge clk);
    check("irq_after_w1c", 128'(irq), 128'd0);
`ifdef CAMERA_CSR_IRQ_EN
    do_read("irq_control", 0, 32'h4);
`else
    do_read("irq_control", 0, 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
